// File: rtl/acc_arb_pkg.sv
// rtl/acc_arb_pkg.sv - shared types and constants for the accumulator arbiter
// Contents: arbiter state enum, state width, largest supported requester count.
package acc_arb_pkg;

  localparam int STATE_W  = 2;
  localparam int MAX_NREQ = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } state_t;

endpackage

// File: rtl/acc_arbiter_if.sv
// rtl/acc_arbiter_if.sv - source-side bus between requesters and the accumulator arbiter
// Ports (master = requesters/bench, slave = arbiter):
//   req, lock, wdata : requester -> arbiter
//   gnt, acc_en, acc_in, busy : arbiter -> requesters and accumulator
interface acc_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  import acc_arb_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  acc_en;
  logic [WIDTH-1:0]      acc_in;
  logic                  busy;

  modport master (
    output req, lock, wdata,
    input  gnt, acc_en, acc_in, busy
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, acc_en, acc_in, busy
  );

endinterface

// File: rtl/acc_arbiter_rr_pick.sv
// rtl/acc_arbiter_rr_pick.sv - combinational round-robin winner search
// Ports: eligible (N request bits), ptr (search start index) -> valid, idx (winner).
// The search order is ptr, ptr+1, ... wrapping modulo N with an explicit
// compare so non-power-of-two N wraps correctly.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // One extra bit so ptr+k never overflows before the wrap compare.
  logic [IW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!valid && eligible[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// rtl/acc_arbiter.sv - round-robin arbiter and write sequencer for the accumulator
// Ports: clk, rst_n (async active-low), bus (acc_arbiter_if.slave):
//   req/lock/wdata in, gnt (registered one-hot), acc_en, acc_in, busy out.
// Optional feature: define ACC_ARB_LOCK_EN to let a locked requester keep
// the grant for up to MAX_BURST consecutive cycles.
module acc_arbiter
  import acc_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst_n,
  acc_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic            hold;
  logic [WIDTH-1:0] acc_in_mux;

  // The current grant holder's request is consumed by the coming edge, so
  // a held req re-queues behind everyone else.
  assign eligible = bus.req & ~gnt_q;

  rr_pick #(.N(NREQ), .IW(PW)) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

`ifdef ACC_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST+1);
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  assign hold = (|(gnt_q & bus.req & bus.lock)) &&
                (burst_cnt_q < BW'(MAX_BURST-1));
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign hold        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    ptr_d   = ptr_q;
`ifdef ACC_ARB_LOCK_EN
    burst_cnt_d = '0;
`endif
    if (hold) begin
      // ptr stays put so the rotation resumes where it left off.
      gnt_d   = gnt_q;
      state_d = BURST;
`ifdef ACC_ARB_LOCK_EN
      burst_cnt_d = burst_cnt_q + BW'(1);
`endif
    end else if (pick_valid) begin
      gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
      ptr_d   = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
      state_d = GRANT;
    end else begin
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ACC_ARB_LOCK_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
`ifdef ACC_ARB_LOCK_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // gnt is one-hot or zero, so an OR of masked slices is the mux.
  always_comb begin
    acc_in_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        acc_in_mux = acc_in_mux | bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.acc_en = |gnt_q;
  assign bus.acc_in = acc_in_mux;
  assign bus.busy   = busy_q;

endmodule
